// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and signed compare helper for the conv/pool datapath.
package conv_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned XW = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    function automatic logic signed [DW-1:0] max2(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_pool2x2_if.sv
// Stream/control bundle between the 2x2 max-pool stage and its driver.
interface conv_pool2x2_if;

    logic [conv_pkg::XW-1:0]        W;
    logic                           start;
    logic                           in_valid;
    logic signed [conv_pkg::DW-1:0] data_in;
    logic                           out_valid;
    logic signed [conv_pkg::DW-1:0] data_out;
    logic                           busy;
    logic                           done;

    modport master (
        output W, start, in_valid, data_in,
        input  out_valid, data_out, busy, done
    );

    modport slave (
        input  W, start, in_valid, data_in,
        output out_valid, data_out, busy, done
    );

endinterface

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal pair maxima; one write port, combinational read, shared address.
module pool_line_buf #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/conv_pool2x2.sv
// Streaming 2x2 stride-2 signed max-pool; define POOL_RELU_EN to clamp outputs at zero.
module conv_pool2x2 #(
    parameter int unsigned DW   = conv_pkg::DW,
    parameter int unsigned MAXW = 64
) (
    input  logic          clk,
    input  logic          reset,
    conv_pool2x2_if.slave bus
);

    import conv_pkg::*;

    localparam int unsigned DEPTH = MAXW / 2;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e               state_q, state_d;
    logic [XW-1:0]        wr_q, wr_d;
    logic [XW-1:0]        col_q, col_d;
    logic [XW-1:0]        row_q, row_d;
    logic signed [DW-1:0] hold_q, hold_d;
    logic signed [DW-1:0] data_out_q, data_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept_c;
    logic                 last_col_c;
    logic                 lb_we_c;
    logic [AW-1:0]        lb_addr_c;
    logic [DW-1:0]        lb_rdata_c;
    logic signed [DW-1:0] pm_c;
    logic signed [DW-1:0] pooled_c;

    pool_line_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_line_buf (
        .clk   (clk),
        .we    (lb_we_c),
        .addr  (lb_addr_c),
        .wdata (pm_c),
        .rdata (lb_rdata_c)
    );

    // Next-state, counters and pooling datapath.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        lb_we_c     = 1'b0;

        accept_c   = (state_q == RUN) && bus.in_valid;
        last_col_c = (col_q == wr_q - XW'(1));
        lb_addr_c  = AW'(col_q >> 1);
        pm_c       = max2(hold_q, bus.data_in);
        pooled_c   = max2(lb_rdata_c, pm_c);
`ifdef POOL_RELU_EN
        pooled_c   = max2(pooled_c, '0);
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    wr_d    = (bus.W > XW'(MAXW)) ? XW'(MAXW) : bus.W;
                    col_d   = '0;
                    row_d   = '0;
                    // Maps narrower than one window finish without consuming data.
                    state_d = (wr_d < XW'(2)) ? FIN : RUN;
                end
            end
            RUN: begin
                if (accept_c) begin
                    if (!col_q[0]) begin
                        hold_d = bus.data_in;
                    end else if (!row_q[0]) begin
                        lb_we_c = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        data_out_d  = pooled_c;
                    end
                    if (last_col_c) begin
                        col_d = '0;
                        if (row_q == wr_q - XW'(1)) begin
                            state_d = FIN;
                        end else begin
                            row_d = row_q + XW'(1);
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: doc/conv_pool2x2.md
# conv_pool2x2

Streaming 2×2, stride-2 signed max-pool stage that sits directly downstream of `conv_2D`. It consumes the `(X-H+1)×(X-H+1)` output map in raster order, one 16-bit sample per accepted cycle. It emits `floor(W/2)×floor(W/2)` pooled samples in raster order, then pulses `done`. Only one half-row of pair maxima is buffered; the full map is never stored.

## Interface
Parameters:
- `DW`, 16: sample width; matches `conv_2D` `data_out`.
- `MAXW`, 64: largest supported map width W. Sets the line-buffer depth to `MAXW/2`.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `W`, in, 11: map width, equal to `X-H+1`. Sampled only on `start`.
- `start`, in, 1: arms a new frame. Honoured only in IDLE.
- `in_valid`, in, 1: `data_in` is valid this cycle.
- `data_in`, in, signed `DW`: convolution output sample.
- `out_valid`, out, 1: `data_out` holds a pooled sample.
- `data_out`, out, signed `DW`: pooled sample.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse at end of frame.

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE → RUN on `start`. On this transition: latch `Wr = min(W, MAXW)`, clear `col`/`row`.
  - If `Wr < 2`, go IDLE → FIN instead; no samples are consumed and no outputs are produced.
  - RUN → FIN when the sample at `row=Wr-1`, `col=Wr-1` is accepted.
  - FIN → IDLE unconditionally after one cycle, with `done=1`.
- Acceptance: a sample is accepted only when `in_valid=1` in RUN.
  - `in_valid` in IDLE or FIN is ignored.
  - `start` in RUN or FIN is ignored.
- Counters: `col` increments on each accepted sample. At `Wr-1` it wraps to 0 and `row` increments.
- Horizontal pair:
  - At even `col`, register the sample as `hold`.
  - At odd `col`, form `pm = max(hold, data_in)` (signed).
- Rows:
  - Even `row`, odd `col`: write `pm` into `linebuf[col>>1]`.
  - Odd `row`, odd `col`: output `max(linebuf[col>>1], pm)`.
- Odd `Wr`: the last column (`col=Wr-1`, even) and the last row (`row=Wr-1`, even) are consumed but never contribute to an output.
- Arithmetic: all comparisons are signed at `DW` bits. There is no width growth and no rounding.
- `in_valid` may drop for any number of cycles. The state simply holds.

## Timing
- Reset values:
  - `out_valid=0`, `data_out=0`, `busy=0`, `done=0`.
  - FSM in IDLE; `col`, `row`, `hold` cleared.
  - Line-buffer contents are don't-care.
- Latency:
  - `out_valid` and `data_out` are registered one cycle after the accepted sample that completes a window.
  - `data_out` holds its value until the next output.
- `done` is high in the cycle after the final accepted sample.
  - For even `Wr`, this coincides with the last `out_valid`.
  - For `Wr<2`, `done` is high in the cycle after `start`.
- `busy` is high from the cycle after `start` until FIN.
- Back-to-back frames: `start` may be asserted in the same cycle as `done`. It is honoured one cycle later, once the FSM is back in IDLE.
- Reset mid-frame aborts the frame immediately. No `done` and no partial output are produced.
- Maximum throughput: one input per cycle and one output per 4 inputs.

## Configuration
- `POOL_RELU_EN` defined: each output is `max(0, pooled)`, so negative windows emit 0.
- `POOL_RELU_EN` undefined: raw signed maximum.
- Counters, timing and `done` are identical in both builds.

## Structure
- Package `conv_pkg` contains:
  - constants `DW=16` and `XW=11` (width of `X`/`W`);
  - the FSM `typedef enum {IDLE, RUN, FIN}`;
  - a signed `max2` function.
- Sub-module `pool_line_buf`: register array of `MAXW/2` entries × `DW`, with one write port and one combinational read port, both addressed by `col>>1`.
- The rest (FSM, counters, compare, output registers) lives in `conv_pool2x2`.

## Test plan
- `W=4`, `data_in`=1..16, `in_valid` held high → `out_valid` four times with 6, 8, 14, 16; `done` on the cycle after sample 16, same cycle as 16.
- `W=5`, `data_in`=1..25 → outputs 7, 9, 17, 19; no output for row 4 or col 4; `done` one cycle after sample 25.
- `W=2`, `data_in`=-5,-3,-8,-1 → single output -1 without `POOL_RELU_EN`, 0 with it.
- `W=4`, 1..16 with `in_valid` low on every other cycle, plus stray `in_valid` pulses before `start` → same 6, 8, 14, 16; strays ignored.
- `reset` asserted after sample 7 of a `W=4` frame → outputs clear immediately and no `done`. A fresh `W=4` frame afterwards gives 6, 8, 14, 16.
- `W=1`, and separately `W=0` → `done` one cycle after `start`, no `out_valid`, inputs ignored.
